// File: rtl/seq_chunk_feeder.sv
// seq_chunk_feeder
// Sequence source for one side (S or T) of the PE-array controller.
// The block accepts an ASCII nucleotide stream, stores it as 2-bit codes
// (A=0, C=1, G=2, T=3, case-insensitive), and then serves PE_NUM-base chunks
// on request. Each chunk carries a per-base valid mask and a last flag.
// After the final chunk the read pointer wraps to 0, so the T sequence can
// be replayed once for every S chunk.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   clear      synchronous flush back to IDLE (highest priority)
//   inData     ASCII base, inValid qualifies it, inLast marks the final byte
//   inReady    high while the sequence is being loaded (IDLE/LOAD)
//   request    one-cycle pulse: deliver the next chunk (READY only)
//   rewind     reset the chunk pointer to 0
//   seqOut     chunk data, base i at bits [2i+1:2i]; unused slots read 0
//   seqValid   bit i set when base i is a real base
//   seqLast    chunk is the final chunk of the sequence
//   seqReady   sequence loaded, requests are served
//   seqLen     number of stored bases (saturates at MAX_LEN)
//   error      sticky: invalid character, overflow or empty sequence
module seq_chunk_feeder #(
    parameter int unsigned PE_NUM   = 64,
    parameter int unsigned MAX_LEN  = 1024,
    parameter int unsigned LEN_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            inData,
    input  logic                  inValid,
    input  logic                  inLast,
    output logic                  inReady,
    input  logic                  request,
    input  logic                  rewind,
    output logic [PE_NUM*2-1:0]   seqOut,
    output logic [PE_NUM-1:0]     seqValid,
    output logic                  seqLast,
    output logic                  seqReady,
    output logic [LEN_BITS-1:0]   seqLen,
    output logic                  error
);

    localparam int unsigned ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned N_CHUNKS_MAX = MAX_LEN / PE_NUM;
    localparam int unsigned K_W          = (N_CHUNKS_MAX > 1) ? $clog2(N_CHUNKS_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [1:0]             r_mem [MAX_LEN];
    logic [LEN_BITS-1:0]    r_len;
    logic [K_W-1:0]         r_k;
    logic                   r_err;
    logic [PE_NUM*2-1:0]    r_seq_out;
    logic [PE_NUM-1:0]      r_seq_valid;
    logic                   r_seq_last;

    logic [1:0]             w_code;
    logic                   w_char_ok;
    logic                   w_in_ready;
    logic                   w_hs;
    logic                   w_full;
    logic                   w_store;
    logic [LEN_BITS-1:0]    w_len_after;
    logic                   w_err_set;

    logic [LEN_BITS:0]      w_nchunks;
    logic [K_W-1:0]         w_k_eff;
    logic [K_W-1:0]         w_k_nxt;
    logic [LEN_BITS-1:0]    w_base;
    logic [LEN_BITS-1:0]    w_rem;
    logic [LEN_BITS-1:0]    w_addr;
    logic                   w_is_last;
    logic [PE_NUM*2-1:0]    w_chunk;
    logic [PE_NUM-1:0]      w_valid;

    // ASCII to 2-bit code
    always_comb begin
        w_code    = 2'd0;
        w_char_ok = 1'b0;
        case (inData)
            8'h41, 8'h61: begin w_code = 2'd0; w_char_ok = 1'b1; end
            8'h43, 8'h63: begin w_code = 2'd1; w_char_ok = 1'b1; end
            8'h47, 8'h67: begin w_code = 2'd2; w_char_ok = 1'b1; end
            8'h54, 8'h74: begin w_code = 2'd3; w_char_ok = 1'b1; end
            default:      begin w_code = 2'd0; w_char_ok = 1'b0; end
        endcase
    end

    // The write pointer is the stored length itself: dropped bytes never advance it.
    assign w_in_ready  = (r_state != S_READY);
    assign w_hs        = inValid & w_in_ready;
    assign w_full      = (r_len == LEN_BITS'(MAX_LEN));
    assign w_store     = w_hs & w_char_ok & ~w_full;
    assign w_len_after = w_store ? (r_len + LEN_BITS'(1)) : r_len;
    assign w_err_set   = w_hs & (~w_char_ok | w_full | (inLast & (w_len_after == '0)));

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. IDLE and LOAD treat a handshake identically, so a
    // single-byte sequence completes straight from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_hs) begin
                        if (inLast) begin
                            w_state_nxt = (w_len_after == '0) ? S_IDLE : S_READY;
                        end else begin
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
                S_READY: w_state_nxt = S_READY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Chunk selection. A same-cycle rewind makes chunk 0 the one delivered.
    always_comb begin
        w_nchunks = ((LEN_BITS+1)'(r_len) + (LEN_BITS+1)'(PE_NUM - 1)) / (LEN_BITS+1)'(PE_NUM);
        w_k_eff   = rewind ? '0 : r_k;
        w_base    = LEN_BITS'(w_k_eff) * LEN_BITS'(PE_NUM);
        w_rem     = r_len - w_base;
        w_is_last = (((LEN_BITS+1)'(w_k_eff) + (LEN_BITS+1)'(1)) == w_nchunks);
        w_k_nxt   = w_is_last ? '0 : (w_k_eff + K_W'(1));
        w_chunk   = '0;
        w_valid   = '0;
        w_addr    = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            w_addr     = w_base + LEN_BITS'(i);
            w_valid[i] = (LEN_BITS'(i) < w_rem);
            w_chunk[2*i +: 2] = w_valid[i] ? r_mem[w_addr[ADDR_W-1:0]] : 2'b00;
        end
    end

    // Base buffer: contents are don't-care after reset/clear, so no reset here.
    always_ff @(posedge clk) begin
        if (w_store && !clear) begin
            r_mem[r_len[ADDR_W-1:0]] <= w_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_k         <= '0;
            r_err       <= 1'b0;
            r_seq_out   <= '0;
            r_seq_valid <= '0;
            r_seq_last  <= 1'b0;
        end else if (clear) begin
            r_len       <= '0;
            r_k         <= '0;
            r_err       <= 1'b0;
            r_seq_out   <= '0;
            r_seq_valid <= '0;
            r_seq_last  <= 1'b0;
        end else begin
            r_len <= w_len_after;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if ((r_state == S_READY) && request) begin
                r_seq_out   <= w_chunk;
                r_seq_valid <= w_valid;
                r_seq_last  <= w_is_last;
                r_k         <= w_k_nxt;
            end else if (rewind) begin
                r_k <= '0;
            end
        end
    end

    assign inReady  = w_in_ready;
    assign seqReady = (r_state == S_READY);
    assign seqOut   = r_seq_out;
    assign seqValid = r_seq_valid;
    assign seqLast  = r_seq_last;
    assign seqLen   = r_len;
    assign error    = r_err;

endmodule

// File: doc/seq_chunk_feeder.md
Name: seq_chunk_feeder

Overview:
Sequence source for the PE-array controller's S and T request/chunk interfaces; one instance per sequence.
- Accepts an ASCII nucleotide stream from the host and stores it as 2-bit codes.
- Serves PE_NUM-base chunks, each with a per-base valid mask and a last flag, one chunk per request pulse.
- Rewind and auto-wrap let the T sequence be replayed for every S chunk.

Parameters:
PE_NUM, 64, bases per chunk (equals the PE array size)
MAX_LEN, 1024, buffer capacity in bases; must be a multiple of PE_NUM
LEN_BITS, 11, width of the length counter (holds 0..MAX_LEN)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
clear  input  1  synchronous flush to IDLE
inData  input  8  ASCII base: 'A'/'a', 'C'/'c', 'G'/'g', 'T'/'t'
inValid  input  1  inData valid
inLast  input  1  inData is the final base of the sequence
inReady  output  1  feeder accepts input
request  input  1  one-cycle pulse: deliver next chunk
rewind  input  1  reset read pointer to chunk 0
seqOut  output  PE_NUM*2  chunk; base i at bits [2i+1:2i]
seqValid  output  PE_NUM  bit i set when base i is real
seqLast  output  1  chunk is the final chunk of the sequence
seqReady  output  1  sequence loaded, requests served
seqLen  output  LEN_BITS  number of stored bases
error  output  1  sticky: invalid character, overflow or empty sequence

Behaviour:
- Reset (async) and clear (sync) both:
  - go to IDLE;
  - seqOut=0, seqValid=0, seqLast=0, seqLen=0, error=0;
  - set write pointer and read pointer to 0;
  - buffer contents don't-care.
- Encoding: A=0, C=1, G=2, T=3, case-insensitive.
- Invalid characters: byte is dropped, error=1; its inLast still counts.
- States:
  - IDLE: a handshake (inValid & inReady) goes to LOAD and stores the base if it is valid.
  - LOAD: each handshake stores at the write pointer, then increments the write pointer and seqLen. A handshake with inLast goes to READY, or to IDLE with error=1 if seqLen=0 after the byte.
  - READY: serves requests.
- inReady: combinational, 1 in IDLE/LOAD, 0 in READY; 1 immediately after reset.
- seqReady: 1 only in READY; it rises the cycle after the last byte is accepted.
- Overflow: bases beyond MAX_LEN are dropped, error=1, seqLen saturates at MAX_LEN; the load completes normally on inLast.
- Chunk count: nChunks = ceil(seqLen/PE_NUM). The read pointer k counts chunks.
- Request in READY: outputs are registered and update on the next edge (1-cycle latency), then hold until the next request/rewind/clear.
  - seqOut holds bases k*PE_NUM..k*PE_NUM+PE_NUM-1.
  - seqValid holds the low r bits set, where r = min(PE_NUM, seqLen - k*PE_NUM).
  - Unused base slots in seqOut read 0.
  - seqLast=1 iff k = nChunks-1.
  - k then increments; after the last chunk it wraps to 0 (auto-rewind).
- Request outside READY: ignored, outputs unchanged. This includes a request in the same cycle as the final byte.
- rewind: k=0 next cycle; outputs unchanged.
- rewind & request in the same cycle: chunk 0 is delivered and k becomes 1.
- clear takes priority over all inputs.
- A new sequence requires clear first; READY refuses input.

Test Plan:
Bench configuration: PE_NUM=4, MAX_LEN=16, LEN_BITS=5.
- Load "ACGTTG" with inLast on G → seqLen=6, seqReady=1, error=0. request → next cycle seqOut=8'hE4, seqValid=4'hF, seqLast=0. request → seqOut=8'h0B, seqValid=4'h3, seqLast=1.
- Continue from scenario 1: third request → seqOut=8'hE4, seqLast=0 (wrap). rewind+request in one cycle → 8'hE4. A following request → 8'h0B.
- Load "acgtacgt" (exactly 8 bases) → second chunk seqOut=8'hE4, seqValid=4'hF, seqLast=1. request while inReady=1 before loading → outputs stay 0.
- Load 18 bases 'T' → seqLen=16, error=1, four chunks 8'hFF with valid 4'hF, seqLast on the fourth.
- Load "ANC" with last on C → seqLen=2, error=1, chunk seqOut=8'h04, seqValid=4'h3, seqLast=1. Single byte 'N' with inLast → IDLE, error=1, seqReady=0.
- Assert rst mid-load after 3 bases → all outputs 0, inReady=1. clear in READY simultaneous with request → outputs 0, no chunk delivered.
